// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus between the IF stage (master) and instruction memory (slave).
// The address is the current PC; data is accepted in any cycle where request and ready are both high.
interface if_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  o_Mem_Req;
  logic [DATA_WIDTH-1:0] o_Mem_Addr;
  logic                  i_Mem_Ready;
  logic [DATA_WIDTH-1:0] i_Mem_Data;

  modport master (
    output o_Mem_Req,
    output o_Mem_Addr,
    input  i_Mem_Ready,
    input  i_Mem_Data
  );

  modport slave (
    input  o_Mem_Req,
    input  o_Mem_Addr,
    output i_Mem_Ready,
    output i_Mem_Data
  );
endinterface

// File: rtl/if_stage.sv
// Pipeline instruction-fetch stage: PC register, fetch FSM with a one-word stall buffer, and the IF/ID register.
// Priority of controls: reset > branch > flush > freeze > normal fetch.
module if_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_Freeze,
  input  logic                  i_Flush,
  input  logic                  i_Branch_Taken,
  input  logic [DATA_WIDTH-1:0] i_Branch_Address,
  if_stage_if.master            mem,
  output logic [DATA_WIDTH-1:0] o_Pc,
  output logic [DATA_WIDTH-1:0] o_Instruction,
  output logic                  o_Valid,
  output logic                  o_Busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HELD = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] pc_reg, pc_next;
  logic [DATA_WIDTH-1:0] buf_reg, buf_next;
  logic [DATA_WIDTH-1:0] out_pc_reg, out_pc_next;
  logic [DATA_WIDTH-1:0] out_instr_reg, out_instr_next;
  logic                  out_valid_reg, out_valid_next;

  logic                  ifid_clear;
  logic                  ifid_load;
  logic [DATA_WIDTH-1:0] load_word;
  logic [DATA_WIDTH-1:0] pc_plus4;

  // Wraps modulo 2^DATA_WIDTH by construction.
  assign pc_plus4 = pc_reg + DATA_WIDTH'(4);

  always_comb begin
    state_next = state_reg;
    buf_next   = buf_reg;
    ifid_clear = 1'b0;
    ifid_load  = 1'b0;
    load_word  = mem.i_Mem_Data;

    if (i_Branch_Taken) begin
      ifid_clear = 1'b1;
      buf_next   = '0;
      state_next = S_REQ;
    end else if (i_Flush) begin
      // PC is not advanced, so the discarded word is fetched again.
      ifid_clear = 1'b1;
      buf_next   = '0;
      state_next = S_REQ;
    end else begin
      case (state_reg)
        S_IDLE: begin
          state_next = S_REQ;
          ifid_clear = ~i_Freeze;
        end
        S_REQ: begin
          if (mem.i_Mem_Ready) begin
            if (i_Freeze) begin
              // Park the word so the request can drop while the pipeline is stalled.
              buf_next   = mem.i_Mem_Data;
              state_next = S_HELD;
            end else begin
              ifid_load = 1'b1;
            end
          end else begin
            ifid_clear = ~i_Freeze;
          end
        end
        S_HELD: begin
          if (!i_Freeze) begin
            ifid_load  = 1'b1;
            load_word  = buf_reg;
            state_next = S_REQ;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    pc_next        = pc_reg;
    out_pc_next    = out_pc_reg;
    out_instr_next = out_instr_reg;
    out_valid_next = out_valid_reg;

    if (i_Branch_Taken) begin
      pc_next = i_Branch_Address;
    end else if (ifid_load) begin
      pc_next = pc_plus4;
    end

    if (ifid_clear) begin
      out_pc_next    = '0;
      out_instr_next = '0;
      out_valid_next = 1'b0;
    end else if (ifid_load) begin
      out_pc_next    = pc_plus4;
      out_instr_next = load_word;
      out_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= S_IDLE;
      pc_reg        <= RESET_PC;
      buf_reg       <= '0;
      out_pc_reg    <= '0;
      out_instr_reg <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      buf_reg       <= buf_next;
      out_pc_reg    <= out_pc_next;
      out_instr_reg <= out_instr_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign mem.o_Mem_Req  = (state_reg == S_REQ);
  assign mem.o_Mem_Addr = pc_reg;
  assign o_Busy         = mem.o_Mem_Req & ~mem.i_Mem_Ready;
  assign o_Pc           = out_pc_reg;
  assign o_Instruction  = out_instr_reg;
  assign o_Valid        = out_valid_reg;

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios with fixed expectations, then randomized
// control/memory traffic checked against a transaction-level fetch model.
module tb_if_stage;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          freeze, flush, br_taken;
  logic [DW-1:0] br_addr;
  logic [DW-1:0] o_Pc, o_Instruction;
  logic          o_Valid, o_Busy;

  int checks = 0;
  int errors = 0;

  if_stage_if #(.DATA_WIDTH(DW)) bus ();

  if_stage #(.DATA_WIDTH(DW), .RESET_PC(32'h0)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_Freeze         (freeze),
    .i_Flush          (flush),
    .i_Branch_Taken   (br_taken),
    .i_Branch_Address (br_addr),
    .mem              (bus),
    .o_Pc             (o_Pc),
    .o_Instruction    (o_Instruction),
    .o_Valid          (o_Valid),
    .o_Busy           (o_Busy)
  );

  always #5 clk = ~clk;

  // Reference model: fetch pointer, a "started" flag (first cycle after reset fetches nothing),
  // a queue holding at most one stalled word, and the delivered IF/ID contents.
  logic [DW-1:0] m_pc, m_opc, m_ins;
  logic          m_val, m_started;
  logic [DW-1:0] m_held[$];

  function automatic logic m_req();
    return m_started && (m_held.size() == 0);
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_started = 1'b0; m_held.delete();
    m_opc = '0; m_ins = '0; m_val = 1'b0;
  endtask

  task automatic deliver(input logic [DW-1:0] word);
    m_pc  = m_pc + 32'd4;
    m_opc = m_pc;
    m_ins = word;
    m_val = 1'b1;
  endtask

  task automatic bubble();
    m_opc = '0; m_ins = '0; m_val = 1'b0;
  endtask

  task automatic model_clock();
    if (br_taken) begin
      m_pc = br_addr; bubble(); m_held.delete(); m_started = 1'b1;
    end else if (flush) begin
      bubble(); m_held.delete(); m_started = 1'b1;
    end else if (!m_started) begin
      m_started = 1'b1;
      if (!freeze) bubble();
    end else if (m_held.size() != 0) begin
      if (!freeze) begin
        deliver(m_held[0]);
        m_held.delete();
      end
    end else if (bus.i_Mem_Ready) begin
      if (freeze) m_held.push_back(bus.i_Mem_Data);
      else deliver(bus.i_Mem_Data);
    end else if (!freeze) begin
      bubble();
    end
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fz, input logic fl, input logic br, input logic [DW-1:0] ba,
                       input logic rdy, input logic [DW-1:0] dat);
    freeze = fz; flush = fl; br_taken = br; br_addr = ba;
    bus.i_Mem_Ready = rdy; bus.i_Mem_Data = dat;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    $display("reset: pc=%h ins=%h v=%0b req=%0b", o_Pc, o_Instruction, o_Valid, bus.o_Mem_Req);
    checks++; if (o_Pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", o_Pc); end
    checks++; if (o_Instruction !== 32'h0) begin errors++; $display("FAIL reset_ins got %h want 0", o_Instruction); end
    checks++; if (o_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_Valid); end
    checks++; if (bus.o_Mem_Req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", bus.o_Mem_Req); end
    checks++; if (bus.o_Mem_Addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", bus.o_Mem_Addr); end
    checks++; if (o_Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_Busy); end
  endtask

  task automatic test_stream();
    reset = 1'b1;
    drive(0, 0, 0, 32'h0, 1, 32'hE000_0001);
    #1;
    checks++; if (bus.o_Mem_Req !== 1'b0) begin errors++; $display("FAIL idle_req got %b want 0", bus.o_Mem_Req); end
    tick();
    checks++; if (bus.o_Mem_Req !== 1'b1 || bus.o_Mem_Addr !== 32'h0) begin errors++; $display("FAIL first_req got req=%b addr=%h want 1/0", bus.o_Mem_Req, bus.o_Mem_Addr); end
    tick();
    $display("stream: pc=%h ins=%h v=%0b", o_Pc, o_Instruction, o_Valid);
    checks++; if (o_Instruction !== 32'hE000_0001 || o_Pc !== 32'h4 || o_Valid !== 1'b1) begin errors++; $display("FAIL stream1 got %h/%h/%b want E0000001/4/1", o_Instruction, o_Pc, o_Valid); end
    checks++; if (bus.o_Mem_Addr !== 32'h4) begin errors++; $display("FAIL stream1_addr got %h want 4", bus.o_Mem_Addr); end
    bus.i_Mem_Data = 32'hE000_0002;
    tick();
    $display("stream: pc=%h ins=%h v=%0b", o_Pc, o_Instruction, o_Valid);
    checks++; if (o_Instruction !== 32'hE000_0002 || o_Pc !== 32'h8 || o_Valid !== 1'b1) begin errors++; $display("FAIL stream2 got %h/%h/%b want E0000002/8/1", o_Instruction, o_Pc, o_Valid); end
  endtask

  task automatic test_wait();
    bus.i_Mem_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (o_Busy !== 1'b1 || bus.o_Mem_Addr !== 32'h8) begin errors++; $display("FAIL wait_busy[%0d] got busy=%b addr=%h want 1/8", i, o_Busy, bus.o_Mem_Addr); end
      tick();
      $display("wait: pc=%h ins=%h v=%0b", o_Pc, o_Instruction, o_Valid);
      checks++; if (o_Valid !== 1'b0 || o_Instruction !== 32'h0) begin errors++; $display("FAIL wait_bubble[%0d] got v=%b ins=%h want 0/0", i, o_Valid, o_Instruction); end
    end
    drive(0, 0, 0, 32'h0, 1, 32'h1234_5678);
    #1;
    checks++; if (o_Busy !== 1'b0) begin errors++; $display("FAIL wait_ready_busy got %b want 0", o_Busy); end
    tick();
    checks++; if (o_Pc !== 32'hC || o_Instruction !== 32'h1234_5678 || o_Valid !== 1'b1) begin errors++; $display("FAIL wait_done got %h/%h/%b want C/12345678/1", o_Pc, o_Instruction, o_Valid); end
  endtask

  task automatic test_freeze();
    drive(1, 0, 0, 32'h0, 1, 32'hAAAA_5555);
    tick();
    bus.i_Mem_Data = 32'hBAD0_BAD0;
    for (int i = 0; i < 2; i++) begin
      $display("freeze: pc=%h ins=%h v=%0b req=%0b", o_Pc, o_Instruction, o_Valid, bus.o_Mem_Req);
      checks++; if (bus.o_Mem_Req !== 1'b0) begin errors++; $display("FAIL held_req[%0d] got %b want 0", i, bus.o_Mem_Req); end
      checks++; if (o_Pc !== 32'hC || o_Instruction !== 32'h1234_5678 || o_Valid !== 1'b1) begin errors++; $display("FAIL held_ifid[%0d] got %h/%h/%b want C/12345678/1", i, o_Pc, o_Instruction, o_Valid); end
      if (i == 0) tick();
    end
    freeze = 1'b0;
    tick();
    $display("unfreeze: pc=%h ins=%h v=%0b", o_Pc, o_Instruction, o_Valid);
    checks++; if (o_Instruction !== 32'hAAAA_5555 || o_Pc !== 32'h10 || o_Valid !== 1'b1) begin errors++; $display("FAIL unfreeze got %h/%h/%b want AAAA5555/10/1", o_Instruction, o_Pc, o_Valid); end
    checks++; if (bus.o_Mem_Addr !== 32'h10 || bus.o_Mem_Req !== 1'b1) begin errors++; $display("FAIL unfreeze_addr got %h/%b want 10/1", bus.o_Mem_Addr, bus.o_Mem_Req); end
  endtask

  task automatic test_branch_held();
    drive(1, 0, 0, 32'h0, 1, 32'hDEAD_0001);
    tick();
    checks++; if (bus.o_Mem_Req !== 1'b0) begin errors++; $display("FAIL bh_held got req=%b want 0", bus.o_Mem_Req); end
    drive(1, 0, 1, 32'h1000, 1, 32'hDEAD_0002);
    tick();
    $display("branch: pc=%h ins=%h v=%0b addr=%h", o_Pc, o_Instruction, o_Valid, bus.o_Mem_Addr);
    checks++; if (o_Valid !== 1'b0 || o_Instruction !== 32'h0 || o_Pc !== 32'h0) begin errors++; $display("FAIL bh_clear got %h/%h/%b want 0/0/0", o_Pc, o_Instruction, o_Valid); end
    checks++; if (bus.o_Mem_Addr !== 32'h1000 || bus.o_Mem_Req !== 1'b1) begin errors++; $display("FAIL bh_addr got %h/%b want 1000/1", bus.o_Mem_Addr, bus.o_Mem_Req); end
    drive(0, 0, 0, 32'h0, 1, 32'hB000_0001);
    tick();
    checks++; if (o_Pc !== 32'h1004 || o_Instruction !== 32'hB000_0001 || o_Valid !== 1'b1) begin errors++; $display("FAIL bh_fetch got %h/%h/%b want 1004/B0000001/1", o_Pc, o_Instruction, o_Valid); end
  endtask

  task automatic test_flush_wrap();
    drive(0, 0, 1, 32'h20, 0, 32'h0);
    tick();
    drive(0, 1, 0, 32'h0, 1, 32'h1111_2222);
    tick();
    $display("flush: pc=%h ins=%h v=%0b addr=%h", o_Pc, o_Instruction, o_Valid, bus.o_Mem_Addr);
    checks++; if (o_Valid !== 1'b0 || o_Instruction !== 32'h0 || bus.o_Mem_Addr !== 32'h20) begin errors++; $display("FAIL flush got v=%b ins=%h addr=%h want 0/0/20", o_Valid, o_Instruction, bus.o_Mem_Addr); end
    drive(0, 0, 0, 32'h0, 1, 32'h3333_4444);
    tick();
    checks++; if (o_Pc !== 32'h24 || o_Instruction !== 32'h3333_4444) begin errors++; $display("FAIL refetch got %h/%h want 24/33334444", o_Pc, o_Instruction); end
    drive(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0);
    tick();
    drive(0, 0, 0, 32'h0, 1, 32'h5555_6666);
    tick();
    $display("wrap: pc=%h ins=%h v=%0b addr=%h", o_Pc, o_Instruction, o_Valid, bus.o_Mem_Addr);
    checks++; if (o_Pc !== 32'h0 || o_Instruction !== 32'h5555_6666 || o_Valid !== 1'b1) begin errors++; $display("FAIL wrap got %h/%h/%b want 0/55556666/1", o_Pc, o_Instruction, o_Valid); end
    checks++; if (bus.o_Mem_Addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h want 0", bus.o_Mem_Addr); end
  endtask

  task automatic test_reset_mid();
    bus.i_Mem_Data = 32'h7777_8888;
    tick();
    checks++; if (o_Pc !== 32'h4 || o_Valid !== 1'b1) begin errors++; $display("FAIL pre_reset got %h/%b want 4/1", o_Pc, o_Valid); end
    bus.i_Mem_Ready = 1'b0;
    #1;
    checks++; if (o_Busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got %b want 1", o_Busy); end
    #2 reset = 1'b0;
    #1;
    $display("async reset: pc=%h ins=%h v=%0b req=%0b", o_Pc, o_Instruction, o_Valid, bus.o_Mem_Req);
    checks++; if (o_Pc !== 32'h0 || o_Instruction !== 32'h0 || o_Valid !== 1'b0) begin errors++; $display("FAIL async_ifid got %h/%h/%b want 0/0/0", o_Pc, o_Instruction, o_Valid); end
    checks++; if (bus.o_Mem_Req !== 1'b0 || o_Busy !== 1'b0 || bus.o_Mem_Addr !== 32'h0) begin errors++; $display("FAIL async_bus got req=%b busy=%b addr=%h want 0/0/0", bus.o_Mem_Req, o_Busy, bus.o_Mem_Addr); end
    model_reset();
  endtask

  task automatic test_random();
    logic [DW-1:0] ba;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      ba = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : ($urandom & 32'hFFFF_FFFC);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, ba,
            $urandom_range(0, 2) != 0, $urandom);
      #1;
      checks++; if (bus.o_Mem_Req !== m_req() || bus.o_Mem_Addr !== m_pc || o_Busy !== (m_req() && !bus.i_Mem_Ready)) begin errors++; $display("FAIL rnd_bus[%0d] got req=%b addr=%h busy=%b want %b/%h/%b", cyc, bus.o_Mem_Req, bus.o_Mem_Addr, o_Busy, m_req(), m_pc, m_req() && !bus.i_Mem_Ready); end
      tick();
      $display("rnd %0d: fz=%0b fl=%0b br=%0b rdy=%0b -> pc=%h ins=%h v=%0b", cyc, freeze, flush, br_taken, bus.i_Mem_Ready, o_Pc, o_Instruction, o_Valid);
      checks++; if (o_Pc !== m_opc || o_Instruction !== m_ins || o_Valid !== m_val) begin errors++; $display("FAIL rnd_ifid[%0d] got %h/%h/%b want %h/%h/%b", cyc, o_Pc, o_Instruction, o_Valid, m_opc, m_ins, m_val); end
      if ($urandom_range(0, 127) == 0) begin
        #1 reset = 1'b0;
        #1;
        model_reset();
        checks++; if (o_Valid !== 1'b0 || bus.o_Mem_Req !== 1'b0 || bus.o_Mem_Addr !== m_pc) begin errors++; $display("FAIL rnd_reset[%0d] got v=%b req=%b addr=%h want 0/0/%h", cyc, o_Valid, bus.o_Mem_Req, bus.o_Mem_Addr, m_pc); end
        @(posedge clk);
        #1 reset = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wait();
    test_freeze();
    test_branch_held();
    test_flush_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
